// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  // Bits needed to hold values 0..max_count, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: synchronizer, debounce FSM with stability counter,
// and optional auto-repeat of the press strobe (BTN_AUTOREPEAT_EN).
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 0
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12500000
`endif
) (
  input  logic clk,
  input  logic async_reset,
  input  logic raw,
  output logic level,
  output logic re,
  output logic fe
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Acceptance happens on the cycle the count would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw_in;
  logic                   s;
  btn_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic                   rpt_fire;

  assign raw_in = (BTN_ACTIVE_LOW != 0) ? ~raw : raw;
  assign s      = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which is what makes the shift chain a chain.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int               RPT_W      = cnt_width(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes later strobes land every REPEAT_PERIOD.
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt;

  assign rpt_fire = (rpt_cnt == RPT_FIRE);

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      rpt_cnt <= '0;
    end else if (state == IDLE_HIGH && s) begin
      rpt_cnt <= rpt_fire ? RPT_RELOAD : rpt_cnt + RPT_ONE;
    end else begin
      rpt_cnt <= '0;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      re    <= 1'b0;
      fe    <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle; branches only ever raise them.
      re <= 1'b0;
      fe <= 1'b0;
      unique case (state)
        IDLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            level <= 1'b1;
            re    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= CNT_ONE;
          end else begin
            re <= rpt_fire;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            fe    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent debounce channels producing clean levels and edge strobes.
// Define BTN_AUTOREPEAT_EN to add press auto-repeat on held buttons.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 0
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 12500000
`endif
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_re,
  output logic [N_BTN-1:0] btn_fe
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk        (clk),
      .async_reset(async_reset),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .re         (btn_re[i]),
      .fe         (btn_fe[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2;
// a second instance exercises BTN_ACTIVE_LOW=1.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       async_reset;
  logic [2:0] btn_raw, raw_al;
  logic [2:0] level, re, fe;
  logic [2:0] level_al, re_al, fe_al;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(0)
`ifdef BTN_AUTOREPEAT_EN
    , .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
`endif
  ) dut (
    .clk(clk), .async_reset(async_reset), .btn_raw(btn_raw),
    .btn_level(level), .btn_re(re), .btn_fe(fe)
  );

  btn_conditioner #(
    .N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1)
`ifdef BTN_AUTOREPEAT_EN
    , .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
`endif
  ) dut_al (
    .clk(clk), .async_reset(async_reset), .btn_raw(raw_al),
    .btn_level(level_al), .btn_re(re_al), .btn_fe(fe_al)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat);
    checks++;
    assert (lat >= 5 && lat <= 7) else begin
      errors++;
      $error("FAIL %s: observed latency %0d expected 6 +/-1", tag, lat);
    end
  endtask

  // Advance one clock and sample #1 after the edge; strobes must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    assert (((re & fe) | (re_al & fe_al)) == 3'b000) else begin
      errors++;
      $error("FAIL re_fe_overlap: observed re=%b fe=%b re_al=%b fe_al=%b expected no overlap",
             re, fe, re_al, fe_al);
    end
  endtask

  // Bounded wait for a strobe on any masked channel; 99 signals a timeout.
  task automatic wait_pulse(input logic [2:0] mask, input bit use_fe, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      lat++;
      if (((use_fe ? fe : re) & mask) != 3'b000) seen = 1'b1;
    end
    if (!seen) lat = 99;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [2:0]  any;
    logic [31:0] rmask, fmask, exp_r;

    // Reset state
    async_reset = 1'b1;
    btn_raw     = 3'b000;
    raw_al      = 3'b111;
    #12;
    check("rst_level", {29'd0, level}, 32'h0);
    check("rst_re", {29'd0, re}, 32'h0);
    check("rst_fe", {29'd0, fe}, 32'h0);
    check("rst_level_al", {29'd0, level_al}, 32'h0);
    @(posedge clk);
    #1 async_reset = 1'b0;
    tick();
    tick();

    // 1. Clean press on channel 0
    btn_raw = 3'b001;
    wait_pulse(3'b001, 1'b0, lat);
    check_lat("t1_press_lat", lat);
    check("t1_level", {29'd0, level}, 32'h1);
    check("t1_re", {29'd0, re}, 32'h1);
    check("t1_fe", {29'd0, fe}, 32'h0);
    tick();
    check("t1_re_one_cycle", {29'd0, re}, 32'h0);
    check("t1_level_held", {29'd0, level}, 32'h1);

    // 3. Release
    btn_raw = 3'b000;
    wait_pulse(3'b001, 1'b1, lat);
    check_lat("t3_release_lat", lat);
    check("t3_level", {29'd0, level}, 32'h0);
    check("t3_fe", {29'd0, fe}, 32'h1);
    check("t3_re", {29'd0, re}, 32'h0);
    tick();
    check("t3_fe_one_cycle", {29'd0, fe}, 32'h0);

    // 2. Bounce 1,0,1,0 then settle high
    any = 3'b000;
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 3'b001 : 3'b000;
      tick();
      any |= re | fe;
    end
    btn_raw = 3'b001;
    wait_pulse(3'b001, 1'b0, lat);
    check("t2_no_pulse_bouncing", {29'd0, any}, 32'h0);
    check_lat("t2_settle_lat", lat);
    check("t2_level", {29'd0, level}, 32'h1);
    tick();
    tick();
    // 3-cycle low glitch while accepted high must be ignored
    btn_raw = 3'b000;
    tick();
    tick();
    tick();
    btn_raw = 3'b001;
    any = 3'b000;
    for (int i = 0; i < 8; i++) begin
      tick();
      any |= fe;
    end
    check("t2_glitch_no_fe", {29'd0, any}, 32'h0);
    check("t2_glitch_level", {29'd0, level}, 32'h1);
    btn_raw = 3'b000;
    wait_pulse(3'b001, 1'b1, lat);
    check_lat("t2_release_lat", lat);
    tick();
    tick();

    // 4. Simultaneous presses, both polarities
    btn_raw = 3'b111;
    raw_al  = 3'b000;
    wait_pulse(3'b111, 1'b0, lat);
    check_lat("t4_press_lat", lat);
    check("t4_re", {29'd0, re}, 32'h7);
    check("t4_re_al", {29'd0, re_al}, 32'h7);
    check("t4_level_al", {29'd0, level_al}, 32'h7);
    tick();
    check("t4_re_cleared", {29'd0, re | re_al}, 32'h0);
    btn_raw = 3'b000;
    raw_al  = 3'b111;
    wait_pulse(3'b111, 1'b1, lat);
    check("t4_fe", {29'd0, fe}, 32'h7);
    check("t4_fe_al", {29'd0, fe_al}, 32'h7);
    tick();
    tick();

    // 6. Hold after acceptance; release sampled at +21 leaves IDLE_HIGH at +23
    btn_raw = 3'b001;
    wait_pulse(3'b001, 1'b0, lat);
    check_lat("t6_press_lat", lat);
    rmask = '0;
    fmask = '0;
    for (int j = 1; j < 32; j++) begin
      tick();
      rmask[j] = re[0];
      fmask[j] = fe[0];
      if (j == 20) btn_raw = 3'b000;
    end
`ifdef BTN_AUTOREPEAT_EN
    exp_r = (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 19) | (32'd1 << 22);
`else
    exp_r = 32'h0;
`endif
    check("t6_repeat_mask", rmask, exp_r);
    check("t6_release_mask", fmask, 32'd1 << 26);
    tick();
    tick();

    // 5. Reset mid-qualification: ch1 accepted high, ch0 in WAIT_HIGH
    btn_raw = 3'b010;
    wait_pulse(3'b010, 1'b0, lat);
    tick();
    tick();
    btn_raw = 3'b011;
    tick();
    tick();
    tick();
    check("t5_pre_level", {29'd0, level}, 32'h2);
    #2 async_reset = 1'b1;
    #1;
    check("t5_async_level", {29'd0, level}, 32'h0);
    check("t5_async_re_fe", {29'd0, re | fe}, 32'h0);
    @(posedge clk);
    #1 async_reset = 1'b0;
    wait_pulse(3'b011, 1'b0, lat);
    check_lat("t5_after_reset_lat", lat);
    check("t5_re", {29'd0, re}, 32'h3);
    any = 3'b000;
    for (int i = 0; i < 7; i++) begin
      tick();
      any |= re;
    end
    check("t5_single_re", {29'd0, any}, 32'h0);
    check("t5_level", {29'd0, level}, 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
